// File: rtl/mem_bist_pkg.sv
// Shared types for the scratch-memory March BIST: FSM states and the
// per-element descriptor that drives write data, expected data and checking.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M0    = 3'd1,
        ST_M1    = 3'd2,
        ST_M2    = 3'd3,
        ST_M3    = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } bist_state_e;

    typedef struct packed {
        logic active;      // element drives a write this cycle
        logic descending;  // address order
        logic wdata_inv;   // write ~P instead of P
        logic exp_inv;     // expect ~P instead of P
        logic chk_en;      // read data is compared
    } elem_desc_t;

    localparam elem_desc_t ELEM_NONE = '{active: 1'b0, descending: 1'b0, wdata_inv: 1'b0, exp_inv: 1'b0, chk_en: 1'b0};
    localparam elem_desc_t ELEM_M0   = '{active: 1'b1, descending: 1'b0, wdata_inv: 1'b0, exp_inv: 1'b0, chk_en: 1'b0};
    localparam elem_desc_t ELEM_M1   = '{active: 1'b1, descending: 1'b0, wdata_inv: 1'b1, exp_inv: 1'b0, chk_en: 1'b1};
    localparam elem_desc_t ELEM_M2   = '{active: 1'b1, descending: 1'b1, wdata_inv: 1'b0, exp_inv: 1'b1, chk_en: 1'b1};
    localparam elem_desc_t ELEM_M3   = '{active: 1'b1, descending: 1'b0, wdata_inv: 1'b0, exp_inv: 1'b0, chk_en: 1'b1};

    function automatic elem_desc_t elem_desc(input bist_state_e st);
        case (st)
            ST_M0:   return ELEM_M0;
            ST_M1:   return ELEM_M1;
            ST_M2:   return ELEM_M2;
            ST_M3:   return ELEM_M3;
            default: return ELEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-check pipeline for the BIST: registers the expectation of each issued
// read, compares it with the returning data and keeps the first failure.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              issue_en,
    input  logic [DATA_W-1:0] issue_exp,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    logic              chk_en_r;
    logic [DATA_W-1:0] chk_exp_r;
    logic [ADDR_W-1:0] chk_addr_r;
    logic              failed_r;
    logic              pass_r;
    logic [ADDR_W-1:0] fail_addr_r;
    logic [DATA_W-1:0] fail_data_r;
    logic              mismatch_s;

    // Compare the read that was issued last cycle.
    always_comb begin
        mismatch_s = 1'b0;
        if (chk_en_r && (mem_rdata != chk_exp_r)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Check pipeline and sticky first-fail capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_en_r    <= 1'b0;
            chk_exp_r   <= {DATA_W{1'b0}};
            chk_addr_r  <= {ADDR_W{1'b0}};
            failed_r    <= 1'b0;
            pass_r      <= 1'b0;
            fail_addr_r <= {ADDR_W{1'b0}};
            fail_data_r <= {DATA_W{1'b0}};
        end else if (clear) begin
            chk_en_r    <= 1'b0;
            chk_exp_r   <= {DATA_W{1'b0}};
            chk_addr_r  <= {ADDR_W{1'b0}};
            failed_r    <= 1'b0;
            pass_r      <= 1'b1;
            fail_addr_r <= {ADDR_W{1'b0}};
            fail_data_r <= {DATA_W{1'b0}};
        end else begin
            chk_en_r   <= issue_en;
            chk_exp_r  <= issue_exp;
            chk_addr_r <= issue_addr;
            if (mismatch_s) begin
                pass_r <= 1'b0;
                if (!failed_r) begin
                    failed_r    <= 1'b1;
                    fail_addr_r <= chk_addr_r;
                    fail_data_r <= mem_rdata;
                end
            end
        end
    end

    assign pass      = pass_r;
    assign fail_addr = fail_addr_r;
    assign fail_data = fail_data_r;

endmodule

// File: rtl/mem_bist_driver.sv
// March BIST initiator for the scratch memory: sequences four elements over
// all addresses, one access per cycle, and reports pass/first-fail.
module mem_bist_driver
    import mem_bist_pkg::*;
#(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    bist_state_e       state_r;
    bist_state_e       state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;
    elem_desc_t        desc_r;
    elem_desc_t        desc_s;
    logic [DATA_W-1:0] wdata_r;
    logic              issue_en_r;
    logic [DATA_W-1:0] issue_exp_r;
    logic              busy_r;
    logic              done_r;
    logic              last_s;
    logic              clear_s;

    // Next state and counter; element change is decoded from the terminal count.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        clear_s = 1'b0;
        if (desc_r.descending) begin
            last_s = (cnt_r == CNT_ZERO);
        end else begin
            last_s = (cnt_r == CNT_MAX);
        end
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_M0;
                    cnt_s   = CNT_ZERO;
                    clear_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_M0: begin
                if (last_s) begin
                    state_s = ST_M1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_M1: begin
                if (last_s) begin
                    state_s = ST_M2;
                    cnt_s   = CNT_MAX;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_M2: begin
                if (last_s) begin
                    state_s = ST_M3;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_M3: begin
                if (last_s) begin
                    state_s = ST_DRAIN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                state_s = ST_DONE;
                cnt_s   = CNT_ZERO;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        desc_s = elem_desc(state_s);
    end

    // State, counter and every memory/status output are registered from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            desc_r      <= ELEM_NONE;
            wdata_r     <= {DATA_W{1'b0}};
            issue_en_r  <= 1'b0;
            issue_exp_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            desc_r     <= desc_s;
            issue_en_r <= desc_s.chk_en;
            busy_r     <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r     <= (state_s == ST_DONE);
            if (desc_s.active) begin
                wdata_r <= desc_s.wdata_inv ? ~PATTERN : PATTERN;
            end else begin
                wdata_r <= {DATA_W{1'b0}};
            end
            if (desc_s.chk_en) begin
                issue_exp_r <= desc_s.exp_inv ? ~PATTERN : PATTERN;
            end else begin
                issue_exp_r <= {DATA_W{1'b0}};
            end
        end
    end

    mem_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_s),
        .issue_en   (issue_en_r),
        .issue_exp  (issue_exp_r),
        .issue_addr (cnt_r),
        .mem_rdata  (mem_rdata),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data)
    );

    assign mem_addr  = cnt_r;
    assign mem_wr    = desc_r.active;
    assign mem_wdata = wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_mem_bist_driver.sv
// Bench for mem_bist_driver: faulty-memory model, table-driven fault vectors,
// randomized faults against an abstract March model, plus corner sequences.
module tb_mem_bist_driver;

    localparam int          D = 32;
    localparam logic [7:0]  P = 8'h55;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] mem_addr;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy, done, pass;
    logic [4:0] fail_addr;
    logic [7:0] fail_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bist_driver #(.ADDR_W(5), .DATA_W(8), .PATTERN(8'h55)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    // Memory with stuck-at faults on stored bits and an optional one-shot read corruption.
    logic [7:0] mem_q [D];
    logic [7:0] s0m [D];
    logic [7:0] s1m [D];
    int         glitch_idx = -1;
    logic [7:0] glitch_mask = 8'h00;
    int         rd_idx = 0;

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_rdata <= mem_q[mem_addr] ^ ((rd_idx == glitch_idx) ? glitch_mask : 8'h00);
            mem_q[mem_addr] <= (mem_wdata & ~s0m[mem_addr]) | s1m[mem_addr];
        end else begin
            mem_rdata <= mem_q[mem_addr];
        end
        if (busy && mem_wr) rd_idx <= rd_idx + 1;
        else if (!busy) rd_idx <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Access-order monitor: 0..31, 0..31, 31..0, 0..31 writes, then one idle cycle.
    int mon_idx = 0;
    always @(negedge clk) begin
        int e, i;
        logic [4:0] a5;
        logic [7:0] wd;
        if (rst_n && busy) begin
            if (mon_idx < 4 * D) begin
                e  = mon_idx / D;
                i  = mon_idx % D;
                a5 = (e == 2) ? 5'(D - 1 - i) : 5'(i);
                wd = (e == 1) ? ~P : P;
                check("mon_seq", {18'd0, mem_wr, mem_addr, mem_wdata}, {18'd0, 1'b1, a5, wd});
            end else begin
                check("mon_drain_wr", {31'd0, mem_wr}, 32'd0);
            end
            mon_idx++;
        end else begin
            mon_idx = 0;
        end
    end

    // Abstract March: walk the four elements over an array and note the first bad read.
    task automatic model(output logic ep, output logic [4:0] ea, output logic [7:0] ed);
        logic [7:0] m [D];
        logic [7:0] rd, ex, wd;
        int a, k;
        bit found;
        for (int j = 0; j < D; j++) m[j] = 8'h00;
        ep = 1'b1; ea = 5'd0; ed = 8'h00; found = 1'b0; k = 0;
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < D; i++) begin
                a  = (e == 2) ? D - 1 - i : i;
                rd = m[a] ^ ((k == glitch_idx) ? glitch_mask : 8'h00);
                ex = (e == 2) ? ~P : P;
                if (e > 0 && rd != ex) begin
                    ep = 1'b0;
                    if (!found) begin
                        found = 1'b1; ea = 5'(a); ed = rd;
                    end
                end
                wd   = (e == 1) ? ~P : P;
                m[a] = (wd & ~s0m[a]) | s1m[a];
                k++;
            end
        end
    endtask

    task automatic set_faults(input int s0a, input logic [7:0] s0k, input int s1a, input logic [7:0] s1k,
                              input int gi, input logic [7:0] gk);
        for (int j = 0; j < D; j++) begin
            s0m[j] = 8'h00;
            s1m[j] = 8'h00;
        end
        if (s0a >= 0) s0m[s0a] = s0k;
        if (s1a >= 0) s1m[s1a] = s1k;
        glitch_idx  = gi;
        glitch_mask = gk;
    endtask

    // Waits (bounded) for done after the start edge; returns edges counted.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic ep, input logic [4:0] ea, input logic [7:0] ed);
        int n;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_clear"}, {19'd0, pass, fail_addr, fail_data}, {19'd0, 1'b1, 5'd0, 8'h00});
        wait_done(n);
        check({tag, "_latency"}, n, 32'd129);
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, ep});
        check({tag, "_faddr"}, {27'd0, fail_addr}, {27'd0, ea});
        check({tag, "_fdata"}, {24'd0, fail_data}, {24'd0, ed});
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        string      name;
        int         s0a;  logic [7:0] s0k;
        int         s1a;  logic [7:0] s1k;
        int         gi;   logic [7:0] gk;
        logic       ep;   logic [4:0] ea;  logic [7:0] ed;
    } vec_t;

    initial begin
        vec_t vt [6];
        logic ep; logic [4:0] ea; logic [7:0] ed;
        int n;

        vt[0] = '{"ideal",     -1, 8'h00, -1, 8'h00, -1,  8'h00, 1'b1, 5'd0,  8'h00};
        vt[1] = '{"a5b0sa0",    5, 8'h01, -1, 8'h00, -1,  8'h00, 1'b0, 5'd5,  8'h54};
        vt[2] = '{"a31b7sa1",  -1, 8'h00, 31, 8'h80, -1,  8'h00, 1'b0, 5'd31, 8'hD5};
        vt[3] = '{"drain_err", -1, 8'h00, -1, 8'h00, 127, 8'h0F, 1'b0, 5'd31, 8'h5A};
        vt[4] = '{"two_faults", 5, 8'h01,  2, 8'h02, -1,  8'h00, 1'b0, 5'd2,  8'h57};
        vt[5] = '{"m2_only",   -1, 8'h00, 10, 8'h01, -1,  8'h00, 1'b0, 5'd10, 8'hAB};

        set_faults(-1, 8'h00, -1, 8'h00, -1, 8'h00);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr",  {27'd0, mem_addr},  32'd0);
        check("rst_wr",    {31'd0, mem_wr},    32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_done",  {31'd0, done},      32'd0);
        check("rst_pass",  {31'd0, pass},      32'd0);
        check("rst_faddr", {27'd0, fail_addr}, 32'd0);
        check("rst_fdata", {24'd0, fail_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 6; v++) begin
            set_faults(vt[v].s0a, vt[v].s0k, vt[v].s1a, vt[v].s1k, vt[v].gi, vt[v].gk);
            run_and_check(vt[v].name, vt[v].ep, vt[v].ea, vt[v].ed);
        end

        for (int r = 0; r < 6; r++) begin
            int fa;
            logic [7:0] fk;
            fa = int'($urandom_range(0, D - 1));
            fk = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) set_faults(fa, fk, -1, 8'h00, -1, 8'h00);
            else                           set_faults(-1, 8'h00, fa, fk, int'($urandom_range(0, 127)), 8'(1 << $urandom_range(0, 7)));
            model(ep, ea, ed);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            run_and_check("rand", ep, ea, ed);
        end

        // start held through a run, then restart directly from DONE.
        set_faults(-1, 8'h00, -1, 8'h00, -1, 8'h00);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        check("hold_latency", n, 32'd129);
        check("hold_pass", {31'd0, pass}, 32'd1);
        @(posedge clk); #1;
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(n);
        check("restart_latency", n, 32'd129);
        check("restart_pass", {31'd0, pass}, 32'd1);

        // Reset while in M2, then a clean run.
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (70) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_outs", {10'd0, mem_addr, mem_wr, mem_wdata, busy, done, pass, fail_addr},
              32'd0);
        check("midrst_fdata", {24'd0, fail_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_and_check("after_rst", 1'b1, 5'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
